// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the unpipelined RISC-V datapath: walks each
// instruction through FETCH/DECODE/EXEC/MEM/WB, issues strobes and handshakes.
module multicycle_sequencer #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             ir_we,
  input  logic             dec_reg_write,
  input  logic             dec_mem_en,
  input  logic             dec_mem_wr,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             rf_we,
  output logic             pc_we,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             err,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    ERR    = 3'd7
  } state_t;

  localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit          TO_EN  = (TIMEOUT != 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              rw_q, me_q, mw_q;
  logic              waiting, timeout_hit;

  assign state_o = state;

  // A ready arriving on the last allowed cycle suppresses the timeout
  // because waiting is already low in that cycle.
  assign waiting     = ((state == FETCH) && !imem_ready) ||
                       ((state == MEM)   && !dmem_ready);
  assign timeout_hit = TO_EN && waiting && (wait_cnt == WAIT_LAST);

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    rf_we     = 1'b0;
    pc_we     = 1'b0;
    case (state)
      IDLE: begin
        if (run) state_nxt = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ready;
        if (imem_ready)       state_nxt = DECODE;
        else if (timeout_hit) state_nxt = ERR;
      end
      DECODE: begin
        state_nxt = EXEC;
      end
      EXEC: begin
        if (me_q)      state_nxt = MEM;
        else if (rw_q) state_nxt = WB;
        else begin
          pc_we     = 1'b1;
          state_nxt = run ? FETCH : IDLE;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = mw_q;
        if (dmem_ready) begin
          if (mw_q) begin
            pc_we     = 1'b1;
            state_nxt = run ? FETCH : IDLE;
          end else begin
            state_nxt = WB;
          end
        end else if (timeout_hit) begin
          state_nxt = ERR;
        end
      end
      WB: begin
        rf_we     = 1'b1;
        pc_we     = 1'b1;
        state_nxt = run ? FETCH : IDLE;
      end
      ERR: begin
        state_nxt = ERR;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      rw_q       <= 1'b0;
      me_q       <= 1'b0;
      mw_q       <= 1'b0;
      err        <= 1'b0;
      retire_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == DECODE) begin
        rw_q <= dec_reg_write;
        me_q <= dec_mem_en;
        mw_q <= dec_mem_wr;
      end
      // Counter is zero outside the wait states, so entry clears it implicitly.
      wait_cnt <= waiting ? wait_cnt + 1'b1 : '0;
      if (state_nxt == ERR) err <= 1'b1;
      if (pc_we) retire_cnt <= retire_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized bench for multicycle_sequencer: an instruction-level model expands
// each instruction into its expected per-cycle outputs, compared every cycle.
module tb_multicycle_sequencer;

  localparam int unsigned TO = 4;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst_n;
  logic          run;
  logic          imem_req;
  logic          imem_ready;
  logic          ir_we;
  logic          dec_reg_write;
  logic          dec_mem_en;
  logic          dec_mem_wr;
  logic          dmem_req;
  logic          dmem_we;
  logic          dmem_ready;
  logic          rf_we;
  logic          pc_we;
  logic [CW-1:0] retire_cnt;
  logic          err;
  logic [2:0]    state_o;

  multicycle_sequencer #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_ready(imem_ready), .ir_we(ir_we),
    .dec_reg_write(dec_reg_write), .dec_mem_en(dec_mem_en), .dec_mem_wr(dec_mem_wr),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .rf_we(rf_we), .pc_we(pc_we), .retire_cnt(retire_cnt),
    .err(err), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One expected cycle: inputs to apply, then outputs the model predicts.
  typedef struct packed {
    logic       run, imr, dmr, rw, me, mw;
    logic [2:0] st;
    logic       imq, irw, dmq, dwe, rf, pc, er;
  } cyc_t;

  cyc_t        q[$];
  logic [13:0] obs;
  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned mcnt   = 0;
  bit          scr    = 1'b0;
  logic [2:0]  cur_flags = 3'b000;

  assign obs = {state_o, imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, err, retire_cnt};

  function automatic logic [13:0] expv(input cyc_t c);
    return {c.st, c.imq, c.irw, c.dmq, c.dwe, c.rf, c.pc, c.er, CW'(mcnt)};
  endfunction

  function automatic cyc_t mk(input logic [2:0] st);
    cyc_t c;
    c     = '0;
    c.st  = st;
    c.run = 1'($urandom);
    c.imr = 1'($urandom);
    c.dmr = 1'($urandom);
    if (scr) {c.rw, c.me, c.mw} = 3'($urandom);
    else     {c.rw, c.me, c.mw} = cur_flags;
    return c;
  endfunction

  task automatic drive(input cyc_t c);
    run           = c.run;
    imem_ready    = c.imr;
    dmem_ready    = c.dmr;
    dec_reg_write = c.rw;
    dec_mem_en    = c.me;
    dec_mem_wr    = c.mw;
  endtask

  task automatic gen_idle(input int n, input bit go);
    cyc_t c;
    for (int i = 0; i < n; i++) begin c = mk(3'd0); c.run = 1'b0; q.push_back(c); end
    if (go) begin c = mk(3'd0); c.run = 1'b1; q.push_back(c); end
  endtask

  task automatic gen_err(input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin c = mk(3'd7); c.er = 1'b1; q.push_back(c); end
  endtask

  // kind: 0 ALU, 1 branch, 2 load, 3 store. fw/dw = cycles of ready low.
  task automatic gen_instr(input int kind, input int fw, input int dw,
                           input bit run_end, input bit scramble);
    cyc_t c;
    bit rw, me, st;
    rw = (kind == 0) || (kind == 2);
    me = (kind >= 2);
    st = (kind == 3);
    scr = scramble;
    cur_flags = {rw, me, st};
    for (int i = 0; i < fw && i < int'(TO); i++) begin
      c = mk(3'd1); c.imr = 1'b0; c.imq = 1'b1; q.push_back(c);
    end
    if (fw >= int'(TO)) begin gen_err(4); return; end
    c = mk(3'd1); c.imr = 1'b1; c.imq = 1'b1; c.irw = 1'b1; q.push_back(c);
    c = mk(3'd2); {c.rw, c.me, c.mw} = {rw, me, st}; q.push_back(c);
    c = mk(3'd3);
    if (kind == 1) begin c.pc = 1'b1; c.run = run_end; q.push_back(c); return; end
    q.push_back(c);
    if (me) begin
      for (int i = 0; i < dw && i < int'(TO); i++) begin
        c = mk(3'd4); c.dmr = 1'b0; c.dmq = 1'b1; c.dwe = st; q.push_back(c);
      end
      if (dw >= int'(TO)) begin gen_err(4); return; end
      c = mk(3'd4); c.dmr = 1'b1; c.dmq = 1'b1; c.dwe = st;
      if (st) begin c.pc = 1'b1; c.run = run_end; q.push_back(c); return; end
      q.push_back(c);
    end
    c = mk(3'd5); c.rf = 1'b1; c.pc = 1'b1; c.run = run_end; q.push_back(c);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0; run = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mcnt  = 0;
  endtask

  task automatic test_reset;
    cyc_t c;
    int   n = 0;
    do_reset(2);
    gen_idle(10, 1'b0);
    while (q.size() != 0) begin
      c = q.pop_front(); drive(c); @(negedge clk); total++;
      if (obs !== expv(c)) $display("FAIL reset_idle cyc %0d: got %h want %h", n, obs, expv(c));
      else passed++;
      if (c.pc) mcnt++;
      n++; @(posedge clk); #1;
    end
  endtask

  task automatic test_alu_stream;
    cyc_t c;
    int   n = 0;
    do_reset(1);
    gen_idle(0, 1'b1);
    for (int i = 0; i < 3; i++) gen_instr(0, 0, 0, i < 2, 1'b0);
    gen_idle(2, 1'b0);
    while (q.size() != 0) begin
      c = q.pop_front(); drive(c); @(negedge clk); total++;
      if (obs !== expv(c)) $display("FAIL alu_stream cyc %0d: got %h want %h", n, obs, expv(c));
      else passed++;
      if (c.pc) mcnt++;
      n++; @(posedge clk); #1;
    end
  endtask

  task automatic test_load_wait;
    cyc_t c;
    int   n = 0;
    do_reset(1);
    gen_idle(0, 1'b1);
    gen_instr(2, 0, 3, 1'b0, 1'b0);
    gen_idle(1, 1'b0);
    while (q.size() != 0) begin
      c = q.pop_front(); drive(c); @(negedge clk); total++;
      if (obs !== expv(c)) $display("FAIL load_wait cyc %0d: got %h want %h", n, obs, expv(c));
      else passed++;
      if (c.pc) mcnt++;
      n++; @(posedge clk); #1;
    end
  endtask

  task automatic test_store_decode;
    cyc_t c;
    int   n = 0;
    do_reset(1);
    gen_idle(0, 1'b1);
    gen_instr(3, 0, 2, 1'b1, 1'b1);
    gen_instr(1, 1, 0, 1'b1, 1'b1);
    gen_instr(0, 0, 0, 1'b1, 1'b1);
    gen_instr(3, 2, 0, 1'b0, 1'b1);
    gen_idle(1, 1'b0);
    while (q.size() != 0) begin
      c = q.pop_front(); drive(c); @(negedge clk); total++;
      if (obs !== expv(c)) $display("FAIL store_decode cyc %0d: got %h want %h", n, obs, expv(c));
      else passed++;
      if (c.pc) mcnt++;
      n++; @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout;
    cyc_t c;
    int   n = 0;
    do_reset(1);
    gen_idle(0, 1'b1);
    gen_instr(0, 3, 0, 1'b1, 1'b0);
    gen_instr(2, 0, 3, 1'b1, 1'b0);
    gen_instr(2, 0, 4, 1'b1, 1'b0);
    while (q.size() != 0) begin
      c = q.pop_front(); drive(c); @(negedge clk); total++;
      if (obs !== expv(c)) $display("FAIL timeout_mem cyc %0d: got %h want %h", n, obs, expv(c));
      else passed++;
      if (c.pc) mcnt++;
      n++; @(posedge clk); #1;
    end
    do_reset(1);
    @(negedge clk); total++;
    if (obs !== 14'h0) $display("FAIL err_reset: got %h want %h", obs, 14'h0);
    else passed++;
    @(posedge clk); #1;
    gen_idle(0, 1'b1);
    gen_instr(1, 4, 0, 1'b1, 1'b0);
    while (q.size() != 0) begin
      c = q.pop_front(); drive(c); @(negedge clk); total++;
      if (obs !== expv(c)) $display("FAIL timeout_fetch cyc %0d: got %h want %h", n, obs, expv(c));
      else passed++;
      if (c.pc) mcnt++;
      n++; @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_mem;
    cyc_t c;
    int   n = 0;
    do_reset(1);
    gen_idle(0, 1'b1);
    gen_instr(0, 0, 0, 1'b1, 1'b0);
    gen_instr(2, 0, 3, 1'b1, 1'b0);
    while (q.size() > 4) begin
      c = q.pop_front(); drive(c); @(negedge clk); total++;
      if (obs !== expv(c)) $display("FAIL mid_mem cyc %0d: got %h want %h", n, obs, expv(c));
      else passed++;
      if (c.pc) mcnt++;
      n++; @(posedge clk); #1;
    end
    q.delete();
    rst_n = 1'b0; run = 1'b1; dmem_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; run = 1'b0; mcnt = 0;
    @(negedge clk); total++;
    if (obs !== 14'h0) $display("FAIL mid_mem_reset: got %h want %h", obs, 14'h0);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap;
    cyc_t c;
    int   n = 0;
    do_reset(1);
    gen_idle(0, 1'b1);
    for (int i = 0; i < 17; i++) gen_instr(0, 0, 0, i < 16, 1'b0);
    gen_idle(1, 1'b0);
    while (q.size() != 0) begin
      c = q.pop_front(); drive(c); @(negedge clk); total++;
      if (obs !== expv(c)) $display("FAIL wrap cyc %0d: got %h want %h", n, obs, expv(c));
      else passed++;
      if (c.pc) mcnt++;
      n++; @(posedge clk); #1;
    end
    total++;
    if (retire_cnt !== CW'(1)) $display("FAIL wrap_count: got %0d want 1", retire_cnt);
    else passed++;
  endtask

  task automatic test_random;
    cyc_t c;
    int   n = 0;
    bit   re;
    do_reset(1);
    gen_idle(0, 1'b1);
    for (int i = 0; i < 30; i++) begin
      re = (i == 29) ? 1'b0 : 1'($urandom);
      gen_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), re, 1'($urandom));
      if (!re && i != 29) gen_idle(int'($urandom_range(0, 2)), 1'b1);
    end
    gen_idle(2, 1'b0);
    while (q.size() != 0) begin
      c = q.pop_front(); drive(c); @(negedge clk); total++;
      if (obs !== expv(c)) $display("FAIL random cyc %0d: got %h want %h", n, obs, expv(c));
      else passed++;
      if (c.pc) mcnt++;
      n++; @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    dec_reg_write = 1'b0; dec_mem_en = 1'b0; dec_mem_wr = 1'b0;
    @(posedge clk); #1;
    test_reset;
    test_alu_stream;
    test_load_wait;
    test_store_decode;
    test_timeout;
    test_reset_mid_mem;
    test_wrap;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule
